// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Request/response bundle between the pipeline MEM stage (master) and the
// data-memory responder (slave).
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_addr              byte address
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata             store data, right-aligned
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              access rejected, memory unchanged
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Target end of the load/store path. Accepts one request at a time, waits
// WAIT_CYCLES, then performs a little-endian byte/half/word access on a
// word-organised RAM and returns extended load data or an error flag.
//
// Ports:
//   clock  system clock, all state changes on posedge
//   reset  synchronous, active-high
//   bus    dmem_responder_if.slave (request and response channels)
//
// Build option: define DMEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses. Without it, misaligned low address bits are ignored (half uses
// addr[1], word uses addr[31:2]).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | req_ready high, waiting for a request
// WAIT   | wait states, down-counter runs to terminal count 1
// ACCESS | single cycle: check request, commit store / extract load
// RESP   | resp_valid high, outputs held until resp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  dmem_responder_if.slave bus
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [31:0]   cur_word;
  logic [31:0]   new_word;
  logic [31:0]   ld_data;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          misalign;
  logic          acc_err;

  always_comb begin
    word_idx = lat_addr[AW+1:2];
    cur_word = mem[word_idx];
    new_word = cur_word;
    ld_data  = '0;
    byte_v   = cur_word[{lat_addr[1:0], 3'b000} +: 8];
    half_v   = cur_word[{lat_addr[1], 4'b0000} +: 16];
    misalign = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign = ((lat_size == 2'b01) && lat_addr[0]) ||
               ((lat_size == 2'b10) && (lat_addr[1:0] != 2'b00));
`endif
    acc_err = (lat_size == 2'b11) || (lat_addr[31:2] >= DEPTH_LIM) || misalign;
    case (lat_size)
      2'b00: begin
        new_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
        ld_data = {{24{~lat_unsigned & byte_v[7]}}, byte_v};
      end
      2'b01: begin
        new_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
        ld_data = {{16{~lat_unsigned & half_v[15]}}, half_v};
      end
      2'b10: begin
        new_word = lat_wdata;
        ld_data  = cur_word;
      end
      default: begin
        new_word = cur_word;
        ld_data  = '0;
      end
    endcase
  end

  // RAM has no reset; a reset asserted in the ACCESS cycle suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && (state == S_ACCESS) && lat_write && !acc_err)
      mem[word_idx] <= new_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      lat_write      <= 1'b0;
      lat_addr       <= '0;
      lat_size       <= '0;
      lat_unsigned   <= 1'b0;
      lat_wdata      <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            lat_write     <= bus.req_write;
            lat_addr      <= bus.req_addr;
            lat_size      <= bus.req_size;
            lat_unsigned  <= bus.req_unsigned;
            lat_wdata     <= bus.req_wdata;
            wait_cnt      <= WAIT_INIT;
            bus.req_ready <= 1'b0;
            state         <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end else begin
            // req_ready comes up one cycle after reset release.
            bus.req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1)
            state <= S_ACCESS;
        end
        S_ACCESS: begin
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= acc_err;
          bus.resp_rdata <= (acc_err || lat_write) ? 32'd0 : ld_data;
          state          <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=2, one with
// WAIT_CYCLES=0. Expected responses are queued when a request is issued and
// checked when the response appears.
module tb_dmem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Returns at the negedge following the accepting edge (cyc == t_acc).
  task automatic issue(input int sel, input logic wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] wdata, output int t_acc);
    logic rdy;
    @(negedge clock);
    if (sel == 1) begin
      bus1.req_write = wr; bus1.req_addr = addr; bus1.req_size = size;
      bus1.req_unsigned = uns; bus1.req_wdata = wdata; bus1.req_valid = 1'b1;
    end else begin
      bus0.req_write = wr; bus0.req_addr = addr; bus0.req_size = size;
      bus0.req_unsigned = uns; bus0.req_wdata = wdata; bus0.req_valid = 1'b1;
    end
    t_acc = -1;
    for (int n = 0; n < 50; n++) begin
      rdy = (sel == 1) ? bus1.req_ready : bus0.req_ready;
      if (rdy) begin
        t_acc = cyc + 1;
        break;
      end
      @(negedge clock);
    end
    if (t_acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    else @(negedge clock);
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int sel, input int t_acc, input int w, input string tag);
    exp_t        e;
    logic        v;
    logic [31:0] rd;
    logic        er;
    int          n;
    n = 0;
    v = (sel == 1) ? bus1.resp_valid : bus0.resp_valid;
    while (!v && n < 50) begin
      @(negedge clock);
      n++;
      v = (sel == 1) ? bus1.resp_valid : bus0.resp_valid;
    end
    if (!v) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk({tag, "_lat"}, 32'(cyc), 32'(t_acc + 1 + w));
    rd = (sel == 1) ? bus1.resp_rdata : bus0.resp_rdata;
    er = (sel == 1) ? bus1.resp_err : bus0.resp_err;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rd, e.rdata);
      chk({tag, "_err"}, {31'd0, er}, {31'd0, e.err});
    end
  endtask

  task automatic xfer(input int sel, input logic wr, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int t;
    push(exp_rdata, exp_err);
    issue(sel, wr, addr, size, uns, wdata, t);
    wait_resp(sel, t, (sel == 1) ? 0 : 2, tag);
    @(negedge clock);
    chk({tag, "_done"}, {31'd0, (sel == 1) ? bus1.resp_valid : bus0.resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    logic [31:0] hold_rd;
    logic        hold_er;
    logic        seen;

    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
    bus0.req_size = '0; bus0.req_unsigned = 1'b0; bus0.req_wdata = '0;
    bus0.resp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
    bus1.req_size = '0; bus1.req_unsigned = 1'b0; bus1.req_wdata = '0;
    bus1.resp_ready = 1'b1;

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", {31'd0, bus0.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
    chk("rst_rdata", bus0.resp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus0.resp_err}, 32'd0);
    reset = 1'b0;

    // word store / load with latency
    xfer(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
    xfer(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");

    // byte and half lanes, sign/zero extension
    xfer(0, 1'b1, 32'h11, 2'b00, 1'b0, 32'h00000080, 32'h0, 1'b0, "sb11");
    xfer(0, 1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, "lb11");
    xfer(0, 1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, "lbu11");
    xfer(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD80EF, 1'b0, "lw10_b");
    xfer(0, 1'b1, 32'h12, 2'b01, 1'b0, 32'h00008001, 32'h0, 1'b0, "sh12");
    xfer(0, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, "lh12");
    xfer(0, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, "lhu12");
    xfer(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h800180EF, 1'b0, "lw10_h");
    xfer(0, 1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 32'hFFFFFFEF, 1'b0, "lb10");
    xfer(0, 1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 32'h000080EF, 1'b0, "lhu10");

    // backpressure
    bus0.resp_ready = 1'b0;
    push(32'h800180EF, 1'b0);
    issue(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, t);
    wait_resp(0, t, 2, "bp_first");
    hold_rd = bus0.resp_rdata;
    hold_er = bus0.resp_err;
    bus0.req_write = 1'b0; bus0.req_addr = 32'h11; bus0.req_size = 2'b00;
    bus0.req_unsigned = 1'b0; bus0.req_wdata = '0; bus0.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_valid", {31'd0, bus0.resp_valid}, 32'd1);
      chk("bp_rdata", bus0.resp_rdata, hold_rd);
      chk("bp_err", {31'd0, bus0.resp_err}, {31'd0, hold_er});
      chk("bp_req_ready", {31'd0, bus0.req_ready}, 32'd0);
    end
    bus0.resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_hs_valid", {31'd0, bus0.resp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, bus0.req_ready}, 32'd1);
    push(32'hFFFFFF80, 1'b0);
    t = cyc + 1;
    @(negedge clock);
    bus0.req_valid = 1'b0;
    chk("bp_second_acc", {31'd0, bus0.req_ready}, 32'd0);
    wait_resp(0, t, 2, "bp_second");
    @(negedge clock);

    // error cases
`ifdef DMEM_ALIGN_CHECK_EN
    xfer(0, 1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, "err_lw12");
    xfer(0, 1'b1, 32'h13, 2'b01, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, "err_sh13");
`else
    xfer(0, 1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 32'h800180EF, 1'b0, "noal_lw12");
`endif
    xfer(0, 1'b1, 32'h10, 2'b11, 1'b0, 32'h11111111, 32'h0, 1'b1, "err_size");
    xfer(0, 1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, "err_lw400");
    xfer(0, 1'b1, 32'h400, 2'b10, 1'b0, 32'h22222222, 32'h0, 1'b1, "err_sw400");
    xfer(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h800180EF, 1'b0, "err_unchanged");
    xfer(0, 1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, "lw_top");

    // zero wait states
    xfer(1, 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, "w0_sw20");
    xfer(1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "w0_lw20");
    xfer(1, 1'b0, 32'h23, 2'b00, 1'b1, 32'h0, 32'h000000CA, 1'b0, "w0_lbu23");

    // reset during WAIT aborts the store
    issue(0, 1'b1, 32'h30, 2'b10, 1'b0, 32'h12345678, t);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_req_ready", {31'd0, bus0.req_ready}, 32'd0);
    chk("abort_resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
    chk("abort_rdata", bus0.resp_rdata, 32'd0);
    chk("abort_err", {31'd0, bus0.resp_err}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      seen = seen | bus0.resp_valid;
    end
    chk("abort_no_resp", {31'd0, seen}, 32'd0);
    xfer(0, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h00000000, 1'b0, "abort_lw30");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
